param_code_lock: RTL and testbench
==================================

# param_code_lock

Parametrised two-button electronic code lock, the successor to the fixed-sequence `lock`. It accepts a serial bit code from buttons `b0`/`b1` and compares complete entries, not a sliding window. A correct entry asserts `unlc` for a programmable hold time. Consecutive failures lead to a timed lockout, and the code can be reprogrammed while the lock is open. It sits between the debounced button synchronisers and the door actuator driver.

## Interface
Parameters:
- `CODE_LEN`, 4: bits per code entry; legal range 2..16.
- `CODE`, 4'b1011: reset value of the code register, `CODE_LEN` bits, MSB entered first.
- `MAX_FAIL`, 3: consecutive wrong entries that trigger lockout; ≥1.
- `UNLOCK_CYCLES`, 5: cycles `unlc` stays high after a correct entry; ≥1.
- `LOCKOUT_CYCLES`, 8: cycles spent in LOCKOUT; ≥1.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `b0`, in, 1: "0" button, synchronous to `clk`.
- `b1`, in, 1: "1" button, synchronous to `clk`.
- `prog`, in, 1: request code reprogramming; honoured only in UNLOCKED.
- `unlc`, out, 1: unlock drive.
- `st`, out, 3: current state encoding.
- `lockout`, out, 1: high while in LOCKOUT.
- `cnt`, out, $clog2(CODE_LEN+1): bits entered in the current entry or programming pass.

## Operation
- Each sampled cycle is decoded as follows:
  - `b1 & ~b0`: press "1".
  - `b0 & ~b1`: press "0".
  - both high: CLEAR.
  - both low: no action.
- States and their `st` encodings: IDLE=0, ENTRY=1, UNLOCKED=2, LOCKOUT=3, PROG=4. Encodings 5–7 are unused and recover to IDLE on the next edge.
- IDLE:
  - A press loads the bit into the entry shift register, sets `cnt`=1 and moves to ENTRY.
  - CLEAR is a no-op.
- ENTRY:
  - A press shifts the bit in at the LSB (the first press ends up as the MSB) and increments `cnt`.
  - CLEAR sets `cnt`=0 and returns to IDLE. It does not count as a failure.
- Compare happens on the press that makes `cnt`==CODE_LEN. The compare uses the shifted-in value including that press.
  - Match: go to UNLOCKED, load the timer with UNLOCK_CYCLES-1, clear the fail counter.
  - Mismatch: increment the fail counter.
    - If the new count equals MAX_FAIL: go to LOCKOUT and load the timer with LOCKOUT_CYCLES-1.
    - Otherwise: go to IDLE.
  - In both cases `cnt` returns to 0.
- UNLOCKED:
  - Button presses are ignored.
  - `prog`=1 goes to PROG with `cnt`=0. `prog` has priority over timer expiry.
  - Otherwise the timer decrements each cycle; when it is 0, go to IDLE.
- PROG:
  - `unlc` stays high.
  - Presses shift into a staging register and `cnt` increments.
  - On the CODE_LEN-th press, the staging value is written to the code register and the state goes to IDLE.
  - CLEAR aborts to IDLE and leaves the code unchanged.
  - There is no timeout.
- LOCKOUT:
  - All inputs are ignored.
  - The timer decrements; at 0, go to IDLE and clear the fail counter.
- The fail counter is $clog2(MAX_FAIL+1) bits, saturates at MAX_FAIL, and clears on correct entry or on lockout exit.

## Timing
- All outputs are registered Moore outputs:
  - `unlc` = (st==UNLOCKED || st==PROG).
  - `lockout` = (st==LOCKOUT).
- Reset values: `st`=0 (IDLE), `unlc`=0, `lockout`=0, `cnt`=0, fail counter=0, timer=0, code register=CODE, entry and staging registers=0.
- Reset mid-operation immediately forces all of the above asynchronously; a partial programming pass is lost.
- Latency: `unlc` rises on the edge that samples the final correct press, i.e. it is visible in the following cycle.
- Without `prog`, `unlc` is high for exactly UNLOCK_CYCLES cycles.
- `lockout` is high for exactly LOCKOUT_CYCLES cycles.
- A press sampled on the same edge as an UNLOCKED or LOCKOUT exit is ignored. The first press counted is the one sampled in IDLE.
- Back-to-back presses with no idle cycles (one per clock) are legal in all entry states.

## Test plan
- Reset release, then presses 1,0,1,1 on consecutive cycles (CODE_LEN=4, CODE=4'b1011) -> `st` walks 1,1,1,2; `unlc`=1 for exactly 5 cycles; `st`=0 afterwards.
- Three wrong entries of 0,0,0,0 -> after the 3rd entry `st`=3 and `lockout`=1 for exactly 8 cycles, and a correct 1,0,1,1 entered during lockout is ignored. After lockout exits, 1,0,1,1 unlocks.
- Presses 1,0 then CLEAR, then 1,0,1,1 -> unlock. `cnt` reads 2 then 0. The fail counter stays 0.
- Two wrong entries, one correct entry, then two more wrong entries -> no lockout, because the fail counter was cleared by the correct entry.
- Unlock, pulse `prog`, press 0,1,1,0 -> `unlc` is held high through PROG, then `st`=0. The sequence 1,0,1,1 now fails and 0,1,1,0 unlocks.
- Assert `rst` low during PROG after 2 bits -> `st`=0, `unlc`=0, `cnt`=0 immediately. The code reverts to 4'b1011.

Source files
------------

// File: rtl/param_code_lock.sv
// Two-button serial code lock: whole-entry compare, timed unlock, failure lockout,
// and in-place code reprogramming while open.
module param_code_lock #(
   parameter int                  CODE_LEN       = 4,
   parameter logic [CODE_LEN-1:0] CODE           = 4'b1011,
   parameter int                  MAX_FAIL       = 3,
   parameter int                  UNLOCK_CYCLES  = 5,
   parameter int                  LOCKOUT_CYCLES = 8
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            b0,
   input  logic                            b1,
   input  logic                            prog,
   output logic                            unlc,
   output logic [2:0]                      st,
   output logic                            lockout,
   output logic [$clog2(CODE_LEN+1)-1:0]   cnt
);

   localparam int CW   = $clog2(CODE_LEN+1);
   localparam int FW   = $clog2(MAX_FAIL+1);
   localparam int TMAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
   localparam int TW   = $clog2(TMAX+1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_ENTRY    = 3'd1,
      S_UNLOCKED = 3'd2,
      S_LOCKOUT  = 3'd3,
      S_PROG     = 3'd4
   } state_t;

   state_t              r_state;
   logic                r_unlc;
   logic                r_lockout;
   logic [CW-1:0]       r_cnt;
   logic [FW-1:0]       r_fail;
   logic [TW-1:0]       r_timer;
   logic [CODE_LEN-1:0] r_code;
   logic [CODE_LEN-1:0] r_entry;
   logic [CODE_LEN-1:0] r_stage;

   logic                w_press;
   logic                w_clear;
   logic                w_bit;
   logic                w_last;
   logic [CODE_LEN-1:0] w_entry_shift;
   logic [CODE_LEN-1:0] w_stage_shift;
   logic [FW-1:0]       w_fail_inc;

   assign w_press       = b0 ^ b1;
   assign w_clear       = b0 & b1;
   assign w_bit         = b1;
   assign w_last        = (r_cnt == CW'(CODE_LEN-1));
   assign w_entry_shift = {r_entry[CODE_LEN-2:0], w_bit};
   assign w_stage_shift = {r_stage[CODE_LEN-2:0], w_bit};
   assign w_fail_inc    = (r_fail == FW'(MAX_FAIL)) ? r_fail : r_fail + FW'(1);

   // Moore outputs are registered alongside the state they describe.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_unlc    <= 1'b0;
         r_lockout <= 1'b0;
         r_cnt     <= '0;
         r_fail    <= '0;
         r_timer   <= '0;
         r_code    <= CODE;
         r_entry   <= '0;
         r_stage   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_press) begin
                  r_entry <= {{(CODE_LEN-1){1'b0}}, w_bit};
                  r_cnt   <= CW'(1);
                  r_state <= S_ENTRY;
               end
            end
            S_ENTRY: begin
               if (w_clear) begin
                  r_cnt   <= '0;
                  r_state <= S_IDLE;
               end else if (w_press) begin
                  r_entry <= w_entry_shift;
                  if (w_last) begin
                     r_cnt <= '0;
                     if (w_entry_shift == r_code) begin
                        r_state <= S_UNLOCKED;
                        r_unlc  <= 1'b1;
                        r_timer <= TW'(UNLOCK_CYCLES-1);
                        r_fail  <= '0;
                     end else if (w_fail_inc == FW'(MAX_FAIL)) begin
                        r_state   <= S_LOCKOUT;
                        r_lockout <= 1'b1;
                        r_timer   <= TW'(LOCKOUT_CYCLES-1);
                        r_fail    <= w_fail_inc;
                     end else begin
                        r_state <= S_IDLE;
                        r_fail  <= w_fail_inc;
                     end
                  end else begin
                     r_cnt <= r_cnt + CW'(1);
                  end
               end
            end
            S_UNLOCKED: begin
               if (prog) begin
                  r_state <= S_PROG;
                  r_cnt   <= '0;
               end else if (r_timer == '0) begin
                  r_state <= S_IDLE;
                  r_unlc  <= 1'b0;
               end else begin
                  r_timer <= r_timer - TW'(1);
               end
            end
            S_PROG: begin
               if (w_clear) begin
                  r_state <= S_IDLE;
                  r_unlc  <= 1'b0;
                  r_cnt   <= '0;
               end else if (w_press) begin
                  r_stage <= w_stage_shift;
                  if (w_last) begin
                     r_code  <= w_stage_shift;
                     r_state <= S_IDLE;
                     r_unlc  <= 1'b0;
                     r_cnt   <= '0;
                  end else begin
                     r_cnt <= r_cnt + CW'(1);
                  end
               end
            end
            S_LOCKOUT: begin
               if (r_timer == '0) begin
                  r_state   <= S_IDLE;
                  r_lockout <= 1'b0;
                  r_fail    <= '0;
               end else begin
                  r_timer <= r_timer - TW'(1);
               end
            end
            default: begin
               r_state   <= S_IDLE;
               r_unlc    <= 1'b0;
               r_lockout <= 1'b0;
               r_cnt     <= '0;
            end
         endcase
      end
   end

   assign st      = r_state;
   assign unlc    = r_unlc;
   assign lockout = r_lockout;
   assign cnt     = r_cnt;

endmodule

// File: tb/tb_param_code_lock.sv
// Scoreboarded directed bench for param_code_lock: stimulus queues the expected
// post-edge state/count, a monitor pops and compares after every edge or reset.
module tb_param_code_lock;

   logic       clk;
   logic       rst;
   logic       b0;
   logic       b1;
   logic       prog;
   logic       unlc;
   logic [2:0] st;
   logic       lockout;
   logic [2:0] cnt;

   typedef struct {
      int st;
      int cnt;
   } exp_t;

   exp_t exp_q[$];
   int   checks;
   int   errors;

   param_code_lock #(
      .CODE_LEN       (4),
      .CODE           (4'b1011),
      .MAX_FAIL       (3),
      .UNLOCK_CYCLES  (5),
      .LOCKOUT_CYCLES (8)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .b0      (b0),
      .b1      (b1),
      .prog    (prog),
      .unlc    (unlc),
      .st      (st),
      .lockout (lockout),
      .cnt     (cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
      end
   endtask

   // Monitor: one comparison set per queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk or negedge rst);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("st", int'(st), e.st);
            check("cnt", int'(cnt), e.cnt);
            check("unlc", int'(unlc), (e.st == 2 || e.st == 4) ? 1 : 0);
            check("lockout", int'(lockout), (e.st == 3) ? 1 : 0);
            $display("t=%0t st=%0d cnt=%0d unlc=%0d lockout=%0d", $time, st, cnt, unlc, lockout);
         end
      end
   end

   task automatic cyc(input logic ib1, input logic ib0, input logic ip,
                      input int est, input int ecnt);
      exp_t e;
      @(negedge clk);
      b1   = ib1;
      b0   = ib0;
      prog = ip;
      e.st  = est;
      e.cnt = ecnt;
      exp_q.push_back(e);
   endtask

   task automatic press(input logic bv, input int est, input int ecnt);
      cyc(bv, ~bv, 1'b0, est, ecnt);
   endtask

   // Four presses MSB first: intermediate state mid, counts 1..3, then fin with cnt 0.
   task automatic code4(input logic [3:0] c, input int mid, input int fin);
      for (int i = 3; i >= 0; i--) begin
         if (i == 0) press(c[i], fin, 0);
         else        press(c[i], mid, 4 - i);
      end
   endtask

   task automatic idle(input int n, input int est);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, est, 0);
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      checks = 0;
      errors = 0;
      rst  = 1'b0;
      b0   = 1'b0;
      b1   = 1'b0;
      prog = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      idle(1, 0);

      // Correct entry, 5-cycle unlock, press on exit edge ignored
      code4(4'b1011, 1, 2);
      idle(4, 2);
      cyc(1'b1, 1'b0, 1'b0, 0, 0);
      idle(1, 0);

      // Partial entry then CLEAR, then correct entry
      press(1'b1, 1, 1);
      press(1'b0, 1, 2);
      cyc(1'b1, 1'b1, 1'b0, 0, 0);
      code4(4'b1011, 1, 2);
      idle(4, 2);
      idle(1, 0);

      // Three wrong entries -> 8-cycle lockout, correct code ignored inside it
      code4(4'b0000, 1, 0);
      code4(4'b0000, 1, 0);
      code4(4'b0000, 1, 3);
      press(1'b1, 3, 0);
      press(1'b0, 3, 0);
      press(1'b1, 3, 0);
      press(1'b1, 3, 0);
      idle(3, 3);
      cyc(1'b1, 1'b0, 1'b0, 0, 0);
      code4(4'b1011, 1, 2);
      idle(4, 2);
      idle(1, 0);

      // Correct entry clears the fail counter
      code4(4'b0000, 1, 0);
      code4(4'b0000, 1, 0);
      code4(4'b1011, 1, 2);
      idle(4, 2);
      idle(1, 0);
      code4(4'b0000, 1, 0);
      code4(4'b0000, 1, 0);
      idle(1, 0);

      // Reprogram to 0110
      code4(4'b1011, 1, 2);
      cyc(1'b0, 1'b0, 1'b1, 4, 0);
      code4(4'b0110, 4, 0);
      code4(4'b1011, 1, 0);
      code4(4'b0110, 1, 2);

      // Reset in the middle of a programming pass
      cyc(1'b0, 1'b0, 1'b1, 4, 0);
      press(1'b1, 4, 1);
      press(1'b0, 4, 2);
      @(negedge clk);
      b0   = 1'b0;
      b1   = 1'b0;
      prog = 1'b0;
      e.st  = 0;
      e.cnt = 0;
      exp_q.push_back(e);
      #2 rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      idle(1, 0);
      code4(4'b1011, 1, 2);
      idle(4, 2);
      idle(1, 0);

      @(negedge clk);
      @(negedge clk);
      check("queue_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
